// File: rtl/nco_pkg.sv
// Shared widths, state encoding and reset constants for the NCO sweep controller.
package nco_pkg;

  localparam int unsigned W_STEP = 24;
  localparam int unsigned W_MOD  = 24;
  localparam int unsigned W_TICK = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sweep_state_t;

  // An all-ones modulo keeps the NCO from ever wrapping while no sweep is configured.
  localparam logic [W_MOD-1:0] MOD_RESET = '1;

endpackage

// File: rtl/nco_step_next.sv
// Next step value with clamping at the sweep bounds.
// NCO_SWEEP_PINGPONG_EN adds a down-count path clamped at the lower bound.
module nco_step_next #(
  parameter int unsigned W = nco_pkg::W_STEP
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] incr,
  input  logic [W-1:0] hi,
`ifdef NCO_SWEEP_PINGPONG_EN
  input  logic [W-1:0] lo,
  input  logic         down,
`endif
  output logic [W-1:0] next
);

  logic [W:0] sum;
`ifdef NCO_SWEEP_PINGPONG_EN
  logic [W:0] diff;
`endif

  always_comb begin
    // One extra bit so the compare sees a true sum and the add can never wrap.
    sum  = {1'b0, cur} + {1'b0, incr};
    next = (sum >= {1'b0, hi}) ? hi : sum[W-1:0];
`ifdef NCO_SWEEP_PINGPONG_EN
    diff = {1'b0, cur} - {1'b0, incr};
    if (down) begin
      next = (diff[W] || (diff[W-1:0] <= lo)) ? lo : diff[W-1:0];
    end
`endif
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped-chirp controller driving the NCO step/mod/mask inputs from a registered sweep.
// Define NCO_SWEEP_PINGPONG_EN for a continuous up/down sweep instead of a one-shot ramp.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int unsigned W_STEP  = nco_pkg::W_STEP,
  parameter int unsigned W_MOD   = nco_pkg::W_MOD,
  parameter int unsigned W_TICK  = nco_pkg::W_TICK,
  parameter int unsigned W_DWELL = 16,
  parameter int unsigned W_CNT   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [W_STEP-1:0]  start_step,
  input  logic [W_STEP-1:0]  stop_step,
  input  logic [W_STEP-1:0]  incr,
  input  logic [W_DWELL-1:0] dwell,
  input  logic [W_MOD-1:0]   mod_in,
  input  logic [W_TICK-1:0]  mask_in,
  input  logic               abort,
  output logic [W_STEP-1:0]  step,
  output logic [W_MOD-1:0]   mod,
  output logic [W_TICK-1:0]  mask,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [W_CNT-1:0]   upd_cnt
);

  sweep_state_t       state_q, state_d;
  logic [W_STEP-1:0]  step_q, step_d;
  logic [W_MOD-1:0]   mod_q, mod_d;
  logic [W_TICK-1:0]  mask_q, mask_d;
  logic [W_STEP-1:0]  stop_q, stop_d;
  logic [W_STEP-1:0]  incr_q, incr_d;
  logic [W_DWELL-1:0] dwell_q, dwell_d;
  logic [W_DWELL-1:0] cnt_q, cnt_d;
  logic [W_CNT-1:0]   upd_q, upd_d;
  logic               cfg_err_q, cfg_err_d;
  logic               cfg_bad;
  logic [W_STEP-1:0]  step_nxt;
  logic               last_value;

`ifdef NCO_SWEEP_PINGPONG_EN
  logic [W_STEP-1:0]  start_q, start_d;
  logic               dir_q, dir_d, dir_eff;

  // Turn around at either bound before computing the next value.
  always_comb begin
    dir_eff = dir_q;
    if (step_q == stop_q) begin
      dir_eff = 1'b1;
    end else if (step_q == start_q) begin
      dir_eff = 1'b0;
    end
  end

  assign last_value = 1'b0;
`else
  assign last_value = (step_q == stop_q);
`endif

  nco_step_next #(
    .W   (W_STEP)
  ) u_step_next (
    .cur  (step_q),
    .incr (incr_q),
    .hi   (stop_q),
`ifdef NCO_SWEEP_PINGPONG_EN
    .lo   (start_q),
    .down (dir_eff),
`endif
    .next (step_nxt)
  );

  always_comb begin
    cfg_bad = (start_step > stop_step) ||
              ({{W_MOD{1'b0}}, stop_step} >= {{W_STEP{1'b0}}, mod_in}) ||
              ((incr == '0) && (start_step != stop_step));
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    mod_d     = mod_q;
    mask_d    = mask_q;
    stop_d    = stop_q;
    incr_d    = incr_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    upd_d     = upd_q;
    cfg_err_d = 1'b0;
`ifdef NCO_SWEEP_PINGPONG_EN
    start_d   = start_q;
    dir_d     = dir_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d = RUN;
            step_d  = start_step;
            mod_d   = mod_in;
            mask_d  = mask_in;
            stop_d  = stop_step;
            incr_d  = incr;
            dwell_d = (dwell == '0) ? W_DWELL'(1) : dwell;
            cnt_d   = W_DWELL'(1);
            upd_d   = '0;
`ifdef NCO_SWEEP_PINGPONG_EN
            start_d = start_step;
            dir_d   = 1'b0;
`endif
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == dwell_q) begin
          if (last_value) begin
            state_d = DONE;
          end else begin
            step_d = step_nxt;
            cnt_d  = W_DWELL'(1);
            upd_d  = upd_q + W_CNT'(1);
`ifdef NCO_SWEEP_PINGPONG_EN
            dir_d  = dir_eff;
`endif
          end
        end else begin
          cnt_d = cnt_q + W_DWELL'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      step_q    <= '0;
      mod_q     <= '1;
      mask_q    <= '0;
      stop_q    <= '0;
      incr_q    <= '0;
      dwell_q   <= W_DWELL'(1);
      cnt_q     <= W_DWELL'(1);
      upd_q     <= '0;
      cfg_err_q <= 1'b0;
`ifdef NCO_SWEEP_PINGPONG_EN
      start_q   <= '0;
      dir_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      mod_q     <= mod_d;
      mask_q    <= mask_d;
      stop_q    <= stop_d;
      incr_q    <= incr_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      upd_q     <= upd_d;
      cfg_err_q <= cfg_err_d;
`ifdef NCO_SWEEP_PINGPONG_EN
      start_q   <= start_d;
      dir_q     <= dir_d;
`endif
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign cfg_err   = cfg_err_q;
  assign step      = step_q;
  assign mod       = mod_q;
  assign mask      = mask_q;
  assign upd_cnt   = upd_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed and randomized sweeps against a step-list model.
module tb_nco_sweep_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [23:0] start_step = '0;
  logic [23:0] stop_step = '0;
  logic [23:0] incr = '0;
  logic [15:0] dwell = '0;
  logic [23:0] mod_in = '0;
  logic [7:0]  mask_in = '0;
  logic        abort = 1'b0;
  logic [23:0] step;
  logic [23:0] mod;
  logic [7:0]  mask;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [15:0] upd_cnt;

  int n_checks = 0;
  int n_fail = 0;

  logic [23:0] exp_step;
  logic [23:0] exp_mod;
  logic [7:0]  exp_mask;
  longint      seq[$];

  always #5 clock = ~clock;

  nco_sweep_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .start_step (start_step),
    .stop_step  (stop_step),
    .incr       (incr),
    .dwell      (dwell),
    .mod_in     (mod_in),
    .mask_in    (mask_in),
    .abort      (abort),
    .step       (step),
    .mod        (mod),
    .mask       (mask),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .upd_cnt    (upd_cnt)
  );

  // The distinct values an upward sweep visits, from the clamped-ramp rule.
  function automatic void fill_seq(input longint s, input longint e, input longint i);
    longint v;
    seq.delete();
    v = s;
    seq.push_back(v);
    while (v != e) begin
      v = (v + i >= e) ? e : v + i;
      seq.push_back(v);
    end
  endfunction

  task automatic drive_cfg(input int unsigned s, input int unsigned e, input int unsigned i,
                           input int unsigned dw, input int unsigned m, input int unsigned mk);
    start_step = s[23:0];
    stop_step  = e[23:0];
    incr       = i[23:0];
    dwell      = dw[15:0];
    mod_in     = m[23:0];
    mask_in    = mk[7:0];
    cfg_valid  = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({step, mod, mask, busy, done, cfg_err, upd_cnt, cfg_ready} !==
        {24'd0, 24'hFFFFFF, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: step=%0d mod=%h mask=%h busy=%b done=%b err=%b upd=%0d rdy=%b",
               step, mod, mask, busy, done, cfg_err, upd_cnt, cfg_ready);
    end
    exp_step = '0;
    exp_mod  = 24'hFFFFFF;
    exp_mask = '0;
  endtask

  // Directed table entries first (basic, clamp, dwell 0 vs 1, single value), then random ones.
  task automatic test_sweeps(input int n_rand);
    int unsigned ts[6] = '{100, 100, 100, 100, 200, 7};
    int unsigned te[6] = '{130, 130, 130, 130, 200, 7};
    int unsigned ti[6] = '{10, 25, 25, 25, 0, 3};
    int unsigned td[6] = '{3, 1, 0, 2, 2, 0};
    int unsigned tm[6] = '{1000, 1000, 1000, 131, 500, 8};
    int unsigned s, e, i, dw, m, mk, d, k, idx;
    logic [42:0] act, expv;
    for (int n = 0; n < 6 + n_rand; n++) begin
      if (n < 6) begin
        s = ts[n]; e = te[n]; i = ti[n]; dw = td[n]; m = tm[n];
      end else begin
        s  = $urandom_range(0, 1000);
        e  = s + $urandom_range(0, 150);
        i  = (e == s) ? $urandom_range(0, 40) : $urandom_range(1, 60);
        dw = $urandom_range(0, 4);
        m  = e + 1 + $urandom_range(0, 3000);
      end
      mk = $urandom_range(0, 255);
      fill_seq(s, e, i);
      k = seq.size();
      d = (dw == 0) ? 1 : dw;
      drive_cfg(s, e, i, dw, m, mk);
      @(negedge clock);
      cfg_valid = 1'b0;
      n_checks++;
      if ({mod, mask} !== {m[23:0], mk[7:0]}) begin
        n_fail++;
        $display("FAIL sweep%0d_load: mod=%0d mask=%0d want mod=%0d mask=%0d", n, mod, mask, m, mk);
      end
      for (int c = 1; c <= int'(k * d) + 2; c++) begin
        idx = (c <= int'(k * d)) ? (c - 1) / d : k - 1;
        act = {step, busy, done, cfg_ready, upd_cnt};
        if (c <= int'(k * d))
          expv = {seq[idx][23:0], 1'b1, 1'b0, 1'b0, idx[15:0]};
        else if (c == int'(k * d) + 1)
          expv = {e[23:0], 1'b1, 1'b1, 1'b0, idx[15:0]};
        else
          expv = {e[23:0], 1'b0, 1'b0, 1'b1, idx[15:0]};
        n_checks++;
        if (act !== expv) begin
          n_fail++;
          $display("FAIL sweep%0d_cycle%0d: step=%0d busy=%b done=%b rdy=%b upd=%0d want %0d %b %b %b %0d",
                   n, c, step, busy, done, cfg_ready, upd_cnt,
                   expv[42:19], expv[18], expv[17], expv[16], expv[15:0]);
        end
        if (c < int'(k * d) + 2) @(negedge clock);
      end
      exp_step = e[23:0];
      exp_mod  = m[23:0];
      exp_mask = mk[7:0];
    end
  endtask

  task automatic test_invalid();
    int unsigned bs[3] = '{0, 50, 5};
    int unsigned be[3] = '{1000, 40, 9};
    int unsigned bi[3] = '{1, 1, 0};
    int unsigned bm[3] = '{1000, 1000, 1000};
    for (int n = 0; n < 3; n++) begin
      drive_cfg(bs[n], be[n], bi[n], 1, bm[n], $urandom_range(0, 255));
      @(negedge clock);
      cfg_valid = 1'b0;
      n_checks++;
      if ({cfg_err, busy, cfg_ready, step, mod, mask} !==
          {1'b1, 1'b0, 1'b1, exp_step, exp_mod, exp_mask}) begin
        n_fail++;
        $display("FAIL invalid%0d_pulse: err=%b busy=%b rdy=%b step=%0d mod=%0d mask=%0d want 1 0 1 %0d %0d %0d",
                 n, cfg_err, busy, cfg_ready, step, mod, mask, exp_step, exp_mod, exp_mask);
      end
      @(negedge clock);
      n_checks++;
      if ({cfg_err, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL invalid%0d_after: err=%b busy=%b want 0 0", n, cfg_err, busy);
      end
    end
  endtask

  task automatic test_abort();
    int seen_done = 0;
    drive_cfg(100, 130, 10, 3, 1000, 8'h3c);
    @(negedge clock);
    cfg_valid = 1'b0;
    repeat (4) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    n_checks++;
    if ({step, busy, cfg_ready, done} !== {24'd110, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_hold: step=%0d busy=%b rdy=%b done=%b want 110 0 1 0",
               step, busy, cfg_ready, done);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      if (done || step !== 24'd110) seen_done++;
    end
    n_checks++;
    if (seen_done != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: %0d bad cycles, want 0", seen_done);
    end
    exp_step = 24'd110;
    exp_mod  = 24'd1000;
    exp_mask = 8'h3c;
  endtask

  task automatic test_reset_mid();
    drive_cfg(300, 400, 7, 2, 5000, 8'h5a);
    @(negedge clock);
    cfg_valid = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_checks++;
    if ({step, mod, mask, cfg_ready, busy, done, upd_cnt} !==
        {24'd0, 24'hFFFFFF, 8'd0, 1'b1, 1'b0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_mid: step=%0d mod=%h mask=%h rdy=%b busy=%b done=%b upd=%0d",
               step, mod, mask, cfg_ready, busy, done, upd_cnt);
    end
    exp_step = '0;
    exp_mod  = 24'hFFFFFF;
    exp_mask = '0;
  endtask

  task automatic test_back_to_back();
    int waited = 0;
    drive_cfg(10, 30, 10, 1, 100, 8'h11);
    @(negedge clock);
    repeat (4) @(negedge clock);
    n_checks++;
    if ({cfg_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_gap: rdy=%b busy=%b want 1 0", cfg_ready, busy);
    end
    @(negedge clock);
    cfg_valid = 1'b0;
    n_checks++;
    if ({busy, step, upd_cnt} !== {1'b1, 24'd10, 16'd0}) begin
      n_fail++;
      $display("FAIL b2b_restart: busy=%b step=%0d upd=%0d want 1 10 0", busy, step, upd_cnt);
    end
    while (busy && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    n_checks++;
    if (busy || step !== 24'd30) begin
      n_fail++;
      $display("FAIL b2b_finish: busy=%b step=%0d after %0d cycles want 0 30", busy, step, waited);
    end
    exp_step = 24'd30;
    exp_mod  = 24'd100;
    exp_mask = 8'h11;
  endtask

`ifdef NCO_SWEEP_PINGPONG_EN
  task automatic test_pingpong();
    longint v = 100;
    int dir = 1;
    drive_cfg(100, 120, 10, 1, 1000, 8'h01);
    @(negedge clock);
    cfg_valid = 1'b0;
    for (int c = 0; c < 14; c++) begin
      n_checks++;
      if ({step, done, busy} !== {v[23:0], 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL pingpong_cycle%0d: step=%0d done=%b busy=%b want %0d 0 1",
                 c, step, done, busy, v);
      end
      if (v == 120) dir = -1;
      else if (v == 100) dir = 1;
      v = v + dir * 10;
      @(negedge clock);
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    exp_step = step;
    exp_mod  = 24'd1000;
    exp_mask = 8'h01;
  endtask
`endif

  initial begin
    test_reset();
`ifdef NCO_SWEEP_PINGPONG_EN
    test_pingpong();
    test_invalid();
`else
    test_sweeps(20);
    test_invalid();
    test_abort();
    test_sweeps(0);
    test_reset_mid();
    test_invalid();
    test_back_to_back();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
